// File: rtl/riscuin_fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory req/ack, decoder valid/ready and redirect.
// master = fetch unit side, slave = memory/decoder/branch-unit side.
interface riscuin_fetch_unit_if #(
  parameter int AW = 10
);
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_rdata;
  logic          instr_valid;
  logic [31:0]   instr;
  logic [AW-1:0] instr_pc;
  logic          instr_ready;
  logic          redirect;
  logic [AW-1:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/riscuin_fetch_unit.sv
// Decoupled fetch: req/ack to imem, PC-tagged prefetch FIFO to decoder; ack in cycle N -> instr_valid in N+1.
// Backpressure: issue stops while queue plus outstanding request would exceed FIFO_DEPTH; redirect flushes.
module riscuin_fetch_unit #(
  parameter int          INSTR_ADDR_WIDTH = 10,
  parameter int          FIFO_DEPTH       = 4,
  parameter int unsigned RESET_PC         = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  riscuin_fetch_unit_if.master              bus,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   level,
  output logic                              pc_end
);

  localparam int AW    = INSTR_ADDR_WIDTH;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [AW-1:0]    RST_PC = AW'(RESET_PC);
  localparam logic [LVL_W-1:0] DEPTH  = LVL_W'(FIFO_DEPTH);

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [31:0]   dat;
  } entry_t;

  entry_t           mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [AW-1:0]    fetch_pc_q, fetch_pc_d, addr_q, addr_d;
  logic             req_q, req_d, discard_q, discard_d, pc_end_q, pc_end_d;
  logic             ack_fire, push, pop, head_vld;

  always_comb begin
    ack_fire   = req_q && bus.imem_ack;
    head_vld   = level_q != '0;
    push       = ack_fire && !discard_q && !bus.redirect;
    pop        = head_vld && bus.instr_ready && !bus.redirect;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    fetch_pc_d = fetch_pc_q;
    pc_end_d   = pc_end_q;
    discard_d  = discard_q;

    if (bus.redirect) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      fetch_pc_d = bus.redirect_pc;
      pc_end_d   = 1'b0;
      // Any request still outstanding after this edge belongs to the old stream.
      discard_d  = req_q && !bus.imem_ack;
    end else begin
      if (ack_fire && discard_q)
        discard_d = 1'b0;
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (fetch_pc_q == '1)
          pc_end_d = 1'b1;
        else
          fetch_pc_d = fetch_pc_q + 1'b1;
      end
      if (pop)
        rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)
        level_d = level_q + 1'b1;
      else if (!push && pop)
        level_d = level_q - 1'b1;
    end

    // A live request is frozen until acked; otherwise decide the next issue.
    req_d  = req_q;
    addr_d = addr_q;
    if (!req_q || bus.imem_ack) begin
      req_d  = en && !pc_end_d && (level_d < DEPTH);
      addr_d = fetch_pc_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      fetch_pc_q <= RST_PC;
      addr_q     <= RST_PC;
      req_q      <= 1'b0;
      discard_q  <= 1'b0;
      pc_end_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      discard_q  <= discard_d;
      pc_end_q   <= pc_end_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= '{pc: fetch_pc_q, dat: bus.imem_rdata};
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = addr_q;
  assign bus.instr_valid = head_vld;
  assign bus.instr       = head_vld ? mem_q[rd_ptr_q].dat : '0;
  assign bus.instr_pc    = head_vld ? mem_q[rd_ptr_q].pc  : '0;
  assign level           = level_q;
  assign pc_end          = pc_end_q;

endmodule

// File: tb/tb_riscuin_fetch_unit.sv
// Directed bench: default-config instance for streaming/backpressure/redirect/reset,
// small-address instance (AW=4, start 14) for end-of-program behaviour.
module tb_riscuin_fetch_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       en_a, en_b;
  logic [2:0] level_a, level_b;
  logic       pc_end_a, pc_end_b;
  int         n_chk  = 0;
  int         n_fail = 0;
  int         acks;
  logic       found;

  always #5 clk = ~clk;

  riscuin_fetch_unit_if #(.AW(10)) a_if ();
  riscuin_fetch_unit_if #(.AW(4))  b_if ();

  assign a_if.imem_rdata = 32'hC0DE_0000 | {22'd0, a_if.imem_addr};
  assign b_if.imem_rdata = 32'hBEEF_0000 | {28'd0, b_if.imem_addr};

  riscuin_fetch_unit #(.INSTR_ADDR_WIDTH(10), .FIFO_DEPTH(4), .RESET_PC(0)) u_a (
    .clk(clk), .rst(rst), .en(en_a), .bus(a_if.master), .level(level_a), .pc_end(pc_end_a)
  );

  riscuin_fetch_unit #(.INSTR_ADDR_WIDTH(4), .FIFO_DEPTH(4), .RESET_PC(14)) u_b (
    .clk(clk), .rst(rst), .en(en_b), .bus(b_if.master), .level(level_b), .pc_end(pc_end_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; en_a = 1'b0; en_b = 1'b0;
    a_if.imem_ack = 1'b0; a_if.instr_ready = 1'b0; a_if.redirect = 1'b0; a_if.redirect_pc = '0;
    b_if.imem_ack = 1'b0; b_if.instr_ready = 1'b0; b_if.redirect = 1'b0; b_if.redirect_pc = '0;
    #3;
    chk("rst_req", a_if.imem_req, 0);
    chk("rst_valid", a_if.instr_valid, 0);
    chk("rst_level", level_a, 0);
    chk("rst_pc_end", pc_end_a, 0);
    chk("rst_instr", a_if.instr, 0);
    chk("rst_instr_pc", a_if.instr_pc, 0);

    // Zero-wait streaming
    a_if.imem_ack = 1'b1; a_if.instr_ready = 1'b1; en_a = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    chk("t1_req", a_if.imem_req, 1);
    chk("t1_addr0", a_if.imem_addr, 0);
    chk("t1_valid_early", a_if.instr_valid, 0);
    tick();
    for (int k = 0; k < 6; k++) begin
      chk("t1_addr", a_if.imem_addr, k + 1);
      chk("t1_valid", a_if.instr_valid, 1);
      chk("t1_pc", a_if.instr_pc, k);
      chk("t1_data", a_if.instr, 32'hC0DE_0000 + k);
      tick();
    end

    // Backpressure fills the queue
    a_if.instr_ready = 1'b0;
    do_reset();
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      if (a_if.imem_req) acks++;
      tick();
    end
    chk("t2_acks", acks, 4);
    chk("t2_req_off", a_if.imem_req, 0);
    chk("t2_level", level_a, 4);
    a_if.instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("t2_pc", a_if.instr_pc, k);
      chk("t2_data", a_if.instr, 32'hC0DE_0000 + k);
      tick();
    end
    chk("t2_resume_pc", a_if.instr_pc, 4);
    chk("t2_resume_valid", a_if.instr_valid, 1);

    // Stalled request at 5 with redirect to 0x40
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (a_if.imem_req && a_if.imem_addr == 10'd5) found = 1'b1;
      else tick();
    end
    chk("t3_wait_addr5", found, 1);
    a_if.imem_ack = 1'b0;
    tick();
    chk("t3_hold_req", a_if.imem_req, 1);
    chk("t3_hold_addr", a_if.imem_addr, 5);
    a_if.redirect = 1'b1; a_if.redirect_pc = 10'h40;
    tick();
    a_if.redirect = 1'b0;
    chk("t3_flush_level", level_a, 0);
    chk("t3_flush_valid", a_if.instr_valid, 0);
    chk("t3_addr_still5", a_if.imem_addr, 5);
    tick();
    tick();
    chk("t3_addr_held", a_if.imem_addr, 5);
    a_if.imem_ack = 1'b1;
    tick();
    chk("t3_stale_dropped", a_if.instr_valid, 0);
    chk("t3_new_addr", a_if.imem_addr, 10'h40);
    tick();
    chk("t3_first_valid", a_if.instr_valid, 1);
    chk("t3_first_pc", a_if.instr_pc, 10'h40);
    chk("t3_first_data", a_if.instr, 32'hC0DE_0040);

    // Redirect colliding with ack of 0x41 and pop of 0x40
    a_if.redirect = 1'b1; a_if.redirect_pc = 10'h100;
    tick();
    a_if.redirect = 1'b0;
    chk("t5_level", level_a, 0);
    chk("t5_valid", a_if.instr_valid, 0);
    chk("t5_addr", a_if.imem_addr, 10'h100);
    chk("t5_req", a_if.imem_req, 1);
    tick();
    chk("t5_pc", a_if.instr_pc, 10'h100);
    chk("t5_data", a_if.instr, 32'hC0DE_0100);

    // Asynchronous reset mid-burst
    a_if.instr_ready = 1'b0;
    tick();
    tick();
    chk("t6_level3", level_a, 3);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_valid", a_if.instr_valid, 0);
    chk("t6_req", a_if.imem_req, 0);
    chk("t6_level", level_a, 0);
    chk("t6_pc_end", pc_end_a, 0);
    tick();
    rst = 1'b1;
    a_if.instr_ready = 1'b1;
    tick();
    chk("t6_restart_req", a_if.imem_req, 1);
    chk("t6_restart_addr", a_if.imem_addr, 0);

    // End of address space on the small instance
    en_a = 1'b0;
    b_if.imem_ack = 1'b1; b_if.instr_ready = 1'b1; en_b = 1'b1;
    tick();
    chk("t4_addr14", b_if.imem_addr, 14);
    chk("t4_req", b_if.imem_req, 1);
    tick();
    chk("t4_addr15", b_if.imem_addr, 15);
    chk("t4_pc14", b_if.instr_pc, 14);
    tick();
    chk("t4_pc_end", pc_end_b, 1);
    chk("t4_req_off", b_if.imem_req, 0);
    chk("t4_pc15", b_if.instr_pc, 15);
    chk("t4_data15", b_if.instr, 32'hBEEF_000F);
    tick();
    tick();
    chk("t4_still_off", b_if.imem_req, 0);
    chk("t4_drained", b_if.instr_valid, 0);
    b_if.redirect = 1'b1; b_if.redirect_pc = 4'd0;
    tick();
    b_if.redirect = 1'b0;
    chk("t4_pc_end_clr", pc_end_b, 0);
    chk("t4_restart_req", b_if.imem_req, 1);
    chk("t4_restart_addr", b_if.imem_addr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/riscuin_fetch_unit.md
Name: riscuin_fetch_unit

Overview:
Parametrised instruction-fetch front end for the next RISCuin core generation. It replaces the single-cycle PC update plus combinational program-memory read with a decoupled unit. The unit issues word-address requests to instruction memory over a req/ack handshake that tolerates variable latency. Returned words go into a prefetch queue tagged with their PC, and the decoder drains them through a valid/ready interface. Branch/jump redirects flush the queue. An end-of-program flag stops fetching at the top of the address space.

Parameters:
INSTR_ADDR_WIDTH, 10, width of the word address (PC without the two zero LSBs).
FIFO_DEPTH, 4, number of prefetch queue entries; power of two, at least 2.
RESET_PC, 0, word address fetched first after reset.

Ports:
clk  input  1  clock; all state is updated on the rising edge.
rst  input  1  asynchronous, active-low reset.
en  input  1  fetch enable; when 0, no new request is issued (a pending request still completes).
imem_req  output  1  instruction memory request.
imem_addr  output  INSTR_ADDR_WIDTH  word address of the request.
imem_ack  input  1  memory accepts the request; imem_rdata is valid in the same cycle.
imem_rdata  input  32  instruction word.
instr_valid  output  1  queue head is valid.
instr  output  32  queue head instruction.
instr_pc  output  INSTR_ADDR_WIDTH  word address of the queue head.
instr_ready  input  1  decoder consumes the head when instr_valid=1.
redirect  input  1  flush the queue and restart fetching at redirect_pc.
redirect_pc  input  INSTR_ADDR_WIDTH  new fetch word address.
level  output  clog2(FIFO_DEPTH+1)  current queue occupancy.
pc_end  output  1  the last address has been fetched; fetching has stopped.

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately):
  - fetch_pc=RESET_PC.
  - Queue empty; level=0; instr_valid=0.
  - imem_req=0; pending=0; discard=0; pc_end=0.
  - instr and instr_pc read 0.
- Issue:
  - imem_req rises when en=1, pc_end=0, pending=0, and level+pending<FIFO_DEPTH.
  - imem_addr=fetch_pc.
  - Once imem_req is high, imem_req and imem_addr are held stable until imem_ack, regardless of en or redirect.
- Transfer: a request completes in the cycle where imem_req=1 and imem_ack=1.
  - With zero-wait memory (ack tied high) the unit issues one request per cycle: after an acked edge, imem_req stays high with imem_addr=fetch_pc+1.
  - Minimum latency: a request acked in cycle N makes instr_valid high in cycle N+1.
- Accepted ack (discard=0, redirect=0):
  - Push {fetch_pc, imem_rdata} into the queue. Space is guaranteed by the issue rule.
  - fetch_pc <= fetch_pc+1.
  - If fetch_pc was all ones, set pc_end=1 and do not wrap the address further. Fetching stops.
- Queue:
  - Strict FIFO.
  - instr_valid = level!=0; instr and instr_pc come from the head.
  - The head is popped when instr_valid&&instr_ready.
  - Simultaneous push and pop leaves level unchanged.
- Redirect (highest priority):
  - Next cycle the queue is empty, level=0, fetch_pc=redirect_pc, pc_end=0.
  - A push in the same cycle is dropped.
  - A pop in the same cycle is ignored; flush wins.
  - If a request is pending and not acked in the redirect cycle, set discard=1. Its later ack is dropped and clears discard. The first request to redirect_pc is issued in the cycle after that ack.
  - If the pending request is acked in the redirect cycle, its data is dropped and discard stays 0.
  - Back-to-back redirects: the last one wins; discard stays set until the stale ack arrives.
- en=0: blocks new issue only. Queue draining and pending completion proceed normally.
- level never exceeds FIFO_DEPTH. The pointers use log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.

Test Plan:
1. Zero-wait memory (ack=1), ready=1, RESET_PC=0:
   - After reset release, imem_addr sequence is 0,1,2,3...
   - instr_valid first rises one cycle after the first ack.
   - instr_pc follows 0,1,2... with no bubbles.
2. ready=0, FIFO_DEPTH=4:
   - Exactly 4 acks, then imem_req=0 and level=4.
   - After ready=1: heads pop as pc 0,1,2,3 with matching data; fetching resumes at 4.
3. Memory stalls ack while imem_addr=5; redirect to 0x40 in that window:
   - imem_addr holds 5 until ack, and that data is dropped.
   - Next request is 0x40; first instr_pc after the flush is 0x40.
4. INSTR_ADDR_WIDTH=4, RESET_PC=14:
   - Fetches 14 then 15; pc_end=1; no further imem_req.
   - Redirect to 0 clears pc_end and fetching restarts at 0.
5. Redirect in the same cycle as an ack and a pop:
   - Next cycle level=0, the acked word never appears, and the next imem_addr is redirect_pc.
6. Assert rst=0 asynchronously mid-burst with level=3:
   - instr_valid, imem_req, level and pc_end drop to 0 before the next clock edge.
   - After release, fetching restarts at RESET_PC.
